wave_synth_core: RTL and testbench

Parametrised four-waveform synthesiser core: a phase accumulator drives sine (parabolic), sawtooth, triangle and square generators. The switch-selected waveforms are averaged into one sample, and a single-bit `Pulse` is produced by PWM or first-order sigma-delta modulation. It replaces the fixed-width generator inside `Main` and adds debounced, auto-repeating, saturating frequency buttons.

---
 rtl/wave_synth_core.sv | 210 +++++++++++++++++++++
 tb/tb_wave_synth_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_synth_core.sv
// wave_synth_core: phase-accumulator synthesiser with sine, saw, triangle and
// square generators, an averaging mixer, and a PWM or sigma-delta output.
// The tuning word is adjusted by two debounced, auto-repeating, saturating
// push buttons.
module wave_synth_core #(
  parameter int ACC_W         = 24,
  parameter int OUT_W         = 8,
  parameter int MODE          = 0,
  parameter int FTW_RESET     = 2**14,
  parameter int FTW_STEP      = 2**10,
  parameter int FTW_MIN       = 0,
  parameter int FTW_MAX       = 2**(ACC_W-1),
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [3:0]       Enable_SW,
  input  logic             Bt_Plus,
  input  logic             Bt_Minus,
  output logic             Pulse,
  output logic [OUT_W-1:0] Mix,
  output logic [ACC_W-1:0] Ftw
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  localparam logic [ACC_W:0]   MaxW   = (ACC_W+1)'(FTW_MAX);
  localparam logic [ACC_W:0]   FloorW = (ACC_W+1)'(FTW_MIN) + (ACC_W+1)'(FTW_STEP);
  localparam logic [ACC_W-1:0] MaxF   = ACC_W'(FTW_MAX);
  localparam logic [ACC_W-1:0] MinF   = ACC_W'(FTW_MIN);
  localparam logic [ACC_W-1:0] StepF  = ACC_W'(FTW_STEP);
  localparam logic [OUT_W-2:0] MaxX   = '1;
  localparam logic [OUT_W-1:0] Half   = {1'b1, {(OUT_W-1){1'b0}}};

  logic [1:0] btnRaw;
  logic [1:0] step;

  assign btnRaw = {Bt_Minus, Bt_Plus};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic             sync1_q, sync2_q, deb_q, debPrev_q;
    logic [DEB_W-1:0] debCnt_q;
    logic [REP_W-1:0] repCnt_q;
    logic             rise, repeatHit;

    assign rise      = deb_q & ~debPrev_q;
    assign repeatHit = deb_q & debPrev_q & (repCnt_q == REP_W'(REPEAT_CYCLES - 1));
    assign step[b]   = rise | repeatHit;

    // Synchronise the button, debounce its level and time the auto-repeat.
    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        deb_q     <= 1'b0;
        debPrev_q <= 1'b0;
        debCnt_q  <= '0;
        repCnt_q  <= '0;
      end else begin
        sync1_q   <= btnRaw[b];
        sync2_q   <= sync1_q;
        debPrev_q <= deb_q;
        if (sync2_q == deb_q) begin
          debCnt_q <= '0;
        end else if (debCnt_q == DEB_W'(DEB_CYCLES - 1)) begin
          deb_q    <= sync2_q;
          debCnt_q <= '0;
        end else begin
          debCnt_q <= debCnt_q + 1'b1;
        end
        if (!deb_q || rise || repeatHit) begin
          repCnt_q <= '0;
        end else begin
          repCnt_q <= repCnt_q + 1'b1;
        end
      end
    end
  end

  logic [ACC_W-1:0] ftw_q, ftw_d, phase_q;
  logic [ACC_W:0]   ftwUp;
  logic [ACC_W-1:0] ftwDown;

  // Saturating tuning-word update; a guard bit keeps the upward sum from wrapping.
  always_comb begin
    ftwUp   = {1'b0, ftw_q} + (ACC_W+1)'(FTW_STEP);
    ftwDown = ftw_q - StepF;
    ftw_d   = ftw_q;
    if (step[0] && !step[1]) begin
      ftw_d = (ftwUp > MaxW) ? MaxF : ftwUp[ACC_W-1:0];
    end else if (step[1] && !step[0]) begin
      ftw_d = ({1'b0, ftw_q} < FloorW) ? MinF : ftwDown;
    end
  end

  // Tuning word and phase accumulator (stage 0).
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      ftw_q   <= ACC_W'(FTW_RESET);
      phase_q <= '0;
    end else begin
      ftw_q   <= ftw_d;
      phase_q <= phase_q + ftw_q;
    end
  end

  logic                 half;
  logic [OUT_W-2:0]     x, xInv;
  logic [2*OUT_W-3:0]   prod;
  logic [OUT_W-1:0]     parab;
  logic [OUT_W-1:0]     sine_q, saw_q, tri_q, sq_q;

  assign half  = phase_q[ACC_W-1];
  assign x     = phase_q[ACC_W-2 -: OUT_W-1];
  assign xInv  = MaxX - x;
  assign prod  = x * xInv;
  assign parab = OUT_W'(prod >> (OUT_W - 3));

  // Waveform registers derived from the current phase (stage 1).
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sine_q <= '0;
      saw_q  <= '0;
      tri_q  <= '0;
      sq_q   <= '0;
    end else begin
      sine_q <= half ? (Half - parab) : (Half + parab);
      saw_q  <= phase_q[ACC_W-1 -: OUT_W];
      tri_q  <= half ? {xInv, 1'b0} : {x, 1'b0};
      sq_q   <= {OUT_W{half}};
    end
  end

  logic [OUT_W+1:0] sumD;
  logic [2:0]       nEn;
  logic [OUT_W+7:0] mul3;
  logic [OUT_W-1:0] mixD, mix_q;
  logic             anyEn_q;

  // Average the enabled waveforms; division by three is approximated by *85/256.
  always_comb begin
    sumD = '0;
    nEn  = '0;
    if (Enable_SW[0]) begin sumD = sumD + (OUT_W+2)'(sine_q); nEn = nEn + 3'd1; end
    if (Enable_SW[1]) begin sumD = sumD + (OUT_W+2)'(saw_q);  nEn = nEn + 3'd1; end
    if (Enable_SW[2]) begin sumD = sumD + (OUT_W+2)'(tri_q);  nEn = nEn + 3'd1; end
    if (Enable_SW[3]) begin sumD = sumD + (OUT_W+2)'(sq_q);   nEn = nEn + 3'd1; end
    mul3 = (OUT_W+8)'(sumD) * (OUT_W+8)'(85);
    case (nEn)
      3'd0:    mixD = '0;
      3'd1:    mixD = sumD[OUT_W-1:0];
      3'd2:    mixD = sumD[OUT_W:1];
      3'd3:    mixD = OUT_W'(mul3 >> 8);
      default: mixD = sumD[OUT_W+1:2];
    endcase
  end

  // Mix register plus an aligned "any waveform enabled" flag (stage 2).
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      mix_q   <= '0;
      anyEn_q <= 1'b0;
    end else begin
      mix_q   <= mixD;
      anyEn_q <= |Enable_SW;
    end
  end

  logic pulse_q;

  if (MODE == 0) begin : g_pwm
    logic [OUT_W-1:0] cnt_q, duty_q;

    // PWM: duty reloads only at counter wrap; disabling all waves forces low at once.
    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
        cnt_q   <= '0;
        duty_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == '1) duty_q <= mix_q;
        pulse_q <= anyEn_q & (cnt_q < duty_q);
      end
    end
  end else begin : g_sd
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W:0]   accSum;

    assign accSum = {1'b0, acc_q} + {1'b0, mix_q};

    // First-order sigma-delta: the output is the carry out of the accumulator.
    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
        acc_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        acc_q   <= accSum[OUT_W-1:0];
        pulse_q <= accSum[OUT_W];
      end
    end
  end

  assign Pulse = pulse_q;
  assign Mix   = mix_q;
  assign Ftw   = ftw_q;

endmodule

// File: tb/tb_wave_synth_core.sv
// tb_wave_synth_core: directed checks of the synthesiser core. The main
// instance runs from the nominal test parameters; two extra instances start
// with a zero tuning word so their phase stays frozen at 0.
module tb_wave_synth_core;

  logic        sysclk = 1'b0;
  logic        resetN;
  logic [3:0]  enMain, enSd, enPw;
  logic        btPlus, btMinus, btnIdle;

  logic        pulseMain, pulseSd, pulsePw;
  logic [7:0]  mixMain, mixSd, mixPw;
  logic [15:0] ftwMain, ftwSd, ftwPw;

  int testCount = 0;
  int failCount = 0;
  int k = 0;
  int triMax;
  int hiCnt;

  always #5 sysclk = ~sysclk;

  wave_synth_core #(.ACC_W(16), .OUT_W(8), .MODE(0), .FTW_RESET(256), .FTW_STEP(64),
                    .FTW_MIN(0), .FTW_MAX(512), .DEB_CYCLES(4), .REPEAT_CYCLES(16))
  dutMain (.sysclk(sysclk), .reset(resetN), .Enable_SW(enMain), .Bt_Plus(btPlus),
           .Bt_Minus(btMinus), .Pulse(pulseMain), .Mix(mixMain), .Ftw(ftwMain));

  wave_synth_core #(.ACC_W(16), .OUT_W(8), .MODE(1), .FTW_RESET(0), .FTW_STEP(64),
                    .FTW_MIN(0), .FTW_MAX(512), .DEB_CYCLES(4), .REPEAT_CYCLES(16))
  dutSd (.sysclk(sysclk), .reset(resetN), .Enable_SW(enSd), .Bt_Plus(btnIdle),
         .Bt_Minus(btnIdle), .Pulse(pulseSd), .Mix(mixSd), .Ftw(ftwSd));

  wave_synth_core #(.ACC_W(16), .OUT_W(8), .MODE(0), .FTW_RESET(0), .FTW_STEP(64),
                    .FTW_MIN(0), .FTW_MAX(512), .DEB_CYCLES(4), .REPEAT_CYCLES(16))
  dutPw (.sysclk(sysclk), .reset(resetN), .Enable_SW(enPw), .Bt_Plus(btnIdle),
         .Bt_Minus(btnIdle), .Pulse(pulsePw), .Mix(mixPw), .Ftw(ftwPw));

  // Advance n clock cycles, leaving the bench 1 time unit past the rising edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
      k++;
    end
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference mixer for the 16-bit phase / 8-bit sample configuration.
  function automatic int mixModel(input int ph, input logic [3:0] en);
    int m, x, saw, sq, triW, p, sine, s, n, r;
    m    = (ph >> 15) & 1;
    x    = (ph >> 8) & 127;
    saw  = (ph >> 8) & 255;
    sq   = (m != 0) ? 255 : 0;
    triW = (m != 0) ? (127 - x) * 2 : x * 2;
    p    = (x * (127 - x)) >> 5;
    sine = (m != 0) ? 128 - p : 128 + p;
    s = 0;
    n = 0;
    if (en[0]) begin s += sine; n++; end
    if (en[1]) begin s += saw;  n++; end
    if (en[2]) begin s += triW; n++; end
    if (en[3]) begin s += sq;   n++; end
    case (n)
      0:       r = 0;
      1:       r = s;
      2:       r = s >> 1;
      3:       r = (s * 85) >> 8;
      default: r = s >> 2;
    endcase
    return r & 255;
  endfunction

  initial begin
    logic [3:0] combos [6];
    combos = '{4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b0011, 4'b0101};

    resetN  = 1'b0;
    enMain  = 4'b0010;
    enSd    = 4'b0001;
    enPw    = 4'b0001;
    btPlus  = 1'b0;
    btMinus = 1'b0;
    btnIdle = 1'b0;

    applyStimulus(3);
    checkOutput("reset_ftw", ftwMain, 256);
    checkOutput("reset_pulse", pulseMain, 0);
    checkOutput("reset_mix", mixMain, 0);

    resetN = 1'b1;
    k = 0;

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1);
      checkOutput("saw_ramp", mixMain, (k < 2) ? 0 : (k - 2) % 256);
    end

    enMain = 4'b1000;
    for (int i = 0; i < 512; i++) begin
      applyStimulus(1);
      checkOutput("square", mixMain, (((k - 2) % 256) >= 128) ? 255 : 0);
    end

    enMain = 4'b0100;
    triMax = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1);
      if (int'(mixMain) > triMax) triMax = int'(mixMain);
      if (((k - 2) % 256) == 0) checkOutput("tri_start", mixMain, 0);
    end
    checkOutput("tri_peak", triMax, 254);

    foreach (combos[c]) begin
      enMain = combos[c];
      for (int i = 0; i < 64; i++) begin
        applyStimulus(1);
        checkOutput("mix_combo", mixMain, mixModel((256 * (k - 2)) & 'hFFFF, enMain));
      end
    end

    enMain = 4'b0000;
    applyStimulus(1);
    checkOutput("off_mix", mixMain, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1);
      checkOutput("off_pulse", pulseMain, 0);
      checkOutput("off_mix_hold", mixMain, 0);
    end

    checkOutput("pw_sine_mix", mixPw, 128);
    checkOutput("sd_sine_mix", mixSd, 128);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("sd_toggle", pulseSd, (k % 2 == 0) ? 1 : 0);
    end

    hiCnt = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1);
      hiCnt += int'(pulsePw);
      if (((k - 1) % 256) == 127) checkOutput("pw_last_high", pulsePw, 1);
      if (((k - 1) % 256) == 128) checkOutput("pw_first_low", pulsePw, 0);
    end
    checkOutput("pw_duty_count", hiCnt, 128);

    enSd = 4'b1111;
    applyStimulus(1);
    checkOutput("mix_all_four", mixSd, 32);
    enSd = 4'b1011;
    applyStimulus(1);
    checkOutput("mix_three", mixSd, 42);
    enSd = 4'b0011;
    applyStimulus(1);
    checkOutput("mix_two", mixSd, 64);
    enSd = 4'b0001;

    btPlus = 1'b1;
    applyStimulus(5);
    checkOutput("btn_latency", ftwMain, 256);
    applyStimulus(5);
    btPlus = 1'b0;
    checkOutput("btn_press", ftwMain, 320);
    applyStimulus(20);
    checkOutput("btn_single_step", ftwMain, 320);

    btPlus = 1'b1;
    applyStimulus(2);
    btPlus = 1'b0;
    applyStimulus(20);
    checkOutput("btn_glitch", ftwMain, 320);

    btPlus  = 1'b1;
    btMinus = 1'b1;
    applyStimulus(10);
    btPlus  = 1'b0;
    btMinus = 1'b0;
    applyStimulus(20);
    checkOutput("btn_cancel", ftwMain, 320);

    btMinus = 1'b1;
    applyStimulus(10);
    btMinus = 1'b0;
    applyStimulus(20);
    checkOutput("btn_minus", ftwMain, 256);

    btPlus = 1'b1;
    applyStimulus(20);
    checkOutput("hold_step1", ftwMain, 320);
    applyStimulus(10);
    checkOutput("hold_step2", ftwMain, 384);
    applyStimulus(10);
    btPlus = 1'b0;
    checkOutput("hold_step3", ftwMain, 448);
    applyStimulus(30);
    checkOutput("hold_release", ftwMain, 448);

    btPlus = 1'b1;
    applyStimulus(100);
    btPlus = 1'b0;
    applyStimulus(20);
    checkOutput("sat_max", ftwMain, 512);

    btMinus = 1'b1;
    applyStimulus(60);
    checkOutput("minus_ramp", ftwMain, 256);
    applyStimulus(140);
    btMinus = 1'b0;
    applyStimulus(20);
    checkOutput("sat_min", ftwMain, 0);

    for (int i = 0; i < 300 && !((((k - 1) % 256) >= 10) && (((k - 1) % 256) < 100)); i++)
      applyStimulus(1);
    checkOutput("pre_reset_pulse", pulsePw, 1);
    resetN = 1'b0;
    #2;
    checkOutput("midreset_pulse", pulsePw, 0);
    checkOutput("midreset_ftw", ftwMain, 256);
    checkOutput("midreset_mix", mixMain, 0);
    checkOutput("midreset_pw_mix", mixPw, 0);
    applyStimulus(2);
    resetN = 1'b1;
    k = 0;

    hiCnt = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1);
      hiCnt += int'(pulsePw);
    end
    checkOutput("relatch_wait", hiCnt, 0);
    applyStimulus(1);
    checkOutput("relatch_high", pulsePw, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
